uart_msg_streamer: RTL
======================

// Module: uart_msg_streamer
// PURPOSE
//  Sends a parallel message of up to MSG_BYTES bytes over an embedded reflet_uart_uart,
//  one-shot on a start pulse or repeatedly while loop is high.
//  Adds the following on top of a fixed-message sender:
//   - runtime length, selectable byte order, programmable inter-byte and inter-message gaps;
//   - a start/busy/done handshake and an abort input;
//   - received bytes passed through to the caller.
//  Used by test firmware and boot banners to emit strings without CPU involvement.
// PARAMETERS
//  CLK_FREQ   1000000  system clock in Hz, passed to the UART
//  BAUD_RATE  9600     line rate, passed to the UART
//  MSG_BYTES  4        capacity of msg in bytes, >=1
//  BYTE_GAP   1        idle clk cycles from end_transmit to next byte start, >=1
//  MSG_GAP    0        extra idle clk cycles between messages in loop mode
//  MSB_FIRST  0        0: send byte 0 (msg[7:0]) first; 1: send byte len-1 first
// PORTS
//  clk       in   1                      system clock
//  reset     in   1                      asynchronous, active-low reset
//  msg       in   8*MSG_BYTES            message, byte k = msg[8k+7:8k]
//  msg_len   in   $clog2(MSG_BYTES+1)    bytes to send; values >MSG_BYTES are clamped to MSG_BYTES
//  start     in   1                      1-cycle request, sampled only in IDLE
//  loop      in   1                      level; when high at message end, resend the message
//  abort     in   1                      1-cycle request to stop after the current byte
//  rx        in   1                      UART receive line
//  tx        out  1                      UART transmit line
//  busy      out  1                      high from the cycle after start is accepted until return to IDLE
//  done      out  1                      1-cycle pulse on normal completion
//  rx_data   out  8                      last received byte
//  rx_valid  out  1                      1-cycle pulse per received byte (UART receive_done)
// BEHAVIOUR
//  Reset values: tx=1, busy=0, done=0, rx_valid=0, rx_data=0.
//   - All state regs reset asynchronously; the FSM goes to IDLE, any frame in flight is dropped.
//  Snapshot: on accept, and at every loop restart, msg and clamped msg_len go into shadow regs.
//   - msg and msg_len may change freely while busy.
//  FSM (all transitions at clk edges):
//   - IDLE: start=1 and len!=0 -> GAP with cnt=BYTE_GAP, idx=0, busy=1 next cycle.
//   - IDLE: start=1 and len==0 -> done=1 for one cycle next cycle, stays IDLE, no tx activity.
//   - GAP: decrement cnt; at cnt==1, issue a 1-cycle UART start_transmit with the selected byte -> WAIT.
//   - WAIT: on end_transmit, idx+1. idx+1<len -> GAP (cnt=BYTE_GAP).
//   - WAIT, last byte, loop=1 and no abort pending -> GAP (cnt=BYTE_GAP+MSG_GAP), idx=0, re-snapshot.
//   - WAIT, last byte, otherwise -> IDLE, done=1, busy=0 in the same cycle.
//  Byte select: idx-th byte, or byte (len-1-idx) when MSB_FIRST=1. idx width is $clog2(MSG_BYTES+1).
//  Abort:
//   - Latched as abort_pending while busy; cleared in IDLE.
//   - In GAP: return to IDLE next cycle, no new byte started.
//   - In WAIT: the current frame completes with a valid stop bit, then IDLE.
//   - An aborted run never pulses done.
//  Simultaneous events:
//   - start while busy is ignored.
//   - abort and start in the same IDLE cycle: start wins, the abort is dropped.
//   - loop sampled only at the last byte's end_transmit.
//  Receive path is independent of the FSM and active in all states except reset.
// TESTING (CLK_FREQ=1000000, BAUD_RATE=100000 -> 10 clk/bit, line BFM decodes tx)
//  1. msg=32'h44434241, len=4, start -> frames 'A','B','C','D';
//     gap between frames >= BYTE_GAP; done one pulse after the 4th stop bit; busy low with it.
//  2. MSB_FIRST=1, msg=32'h00004241, len=2 -> 'B','A'; msg changed to 0 mid-send does not alter output.
//  3. loop=1, len=2 ("AB") -> ABAB..., inter-message idle >= BYTE_GAP+MSG_GAP.
//     Drop loop during the 3rd message -> it completes, then done.
//  4. abort pulsed mid 2nd byte of len=4 -> 2nd frame complete, no 3rd; done stays 0, busy falls.
//  5. len=0 -> done next cycle, tx stays 1. len=7 with MSG_BYTES=4 -> exactly 4 frames.
//     start pulsed while busy -> no effect.
//  6. reset low mid-frame -> tx=1, busy=0, done=0 immediately.
//     Release then start -> full message from byte 0; byte 0x5A on rx -> rx_data=8'h5A with one rx_valid pulse.

Source files
------------

// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer
//   Sends a snapshot of a parallel message, up to MSG_BYTES bytes long, through
//   an embedded UART. It sends once per start pulse, or repeatedly while loop
//   is high. The sender supports a runtime length, a selectable byte order,
//   programmable inter-byte and inter-message gaps, a start/busy/done
//   handshake and an abort request. Bytes received on rx are passed straight
//   through to the caller.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   msg       in   message; byte k = msg[8k+7:8k]
//   msg_len   in   bytes to send; values above MSG_BYTES are clamped
//   start     in   1-cycle request, sampled only in IDLE
//   loop      in   level; when high at message end, the message is resent
//   abort     in   1-cycle request to stop after the current byte
//   rx        in   UART receive line
//   tx        out  UART transmit line
//   busy      out  high while a message is in progress
//   done      out  1-cycle pulse on normal completion
//   rx_data   out  last received byte
//   rx_valid  out  1-cycle pulse per received byte
module uart_msg_streamer #(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned MSG_BYTES = 4,
  parameter int unsigned BYTE_GAP  = 1,
  parameter int unsigned MSG_GAP   = 0,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [8*MSG_BYTES-1:0]             msg,
  input  logic [$clog2(MSG_BYTES+1)-1:0]     msg_len,
  input  logic                               start,
  input  logic                               loop,
  input  logic                               abort,
  input  logic                               rx,
  output logic                               tx,
  output logic                               busy,
  output logic                               done,
  output logic [7:0]                         rx_data,
  output logic                               rx_valid
);

  localparam int unsigned LW = $clog2(MSG_BYTES + 1);
  localparam int unsigned GW = $clog2(BYTE_GAP + MSG_GAP + 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MSG_BYTES);
  localparam logic [GW-1:0] CNT_BYTE = GW'(BYTE_GAP);
  localparam logic [GW-1:0] CNT_MSG  = GW'(BYTE_GAP + MSG_GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [8*MSG_BYTES-1:0] msg_q, msg_d;
  logic [LW-1:0]          len_q, len_d;
  logic [LW-1:0]          idx_q, idx_d;
  logic [GW-1:0]          cnt_q, cnt_d;
  logic                   abort_pend_q, abort_pend_d;
  logic                   done_q, done_d;

  logic [LW-1:0] len_clamped;
  logic [LW:0]   idx_inc;
  logic [LW-1:0] sel;
  logic [7:0]    tx_byte;
  logic          tx_start;
  logic          tx_end;
  logic          abort_now;

  assign len_clamped = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
  assign idx_inc     = {1'b0, idx_q} + {{LW{1'b0}}, 1'b1};
  // An abort that arrives in the same cycle as the decision counts as pending.
  assign abort_now   = abort | abort_pend_q;

  assign sel = MSB_FIRST ? (len_q - idx_q - LW'(1)) : idx_q;

  always_comb begin
    tx_byte = '0;
    for (int unsigned k = 0; k < MSG_BYTES; k++) begin
      if (sel == LW'(k)) tx_byte = msg_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    len_d        = len_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    tx_start     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Abort is dropped here, including when it coincides with start.
        abort_pend_d = 1'b0;
        if (start) begin
          if (len_clamped != '0) begin
            state_d = S_GAP;
            cnt_d   = CNT_BYTE;
            idx_d   = '0;
            msg_d   = msg;
            len_d   = len_clamped;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort_now) begin
          state_d      = S_IDLE;
          abort_pend_d = 1'b0;
        end else if (cnt_q == GW'(1)) begin
          tx_start = 1'b1;
          state_d  = S_WAIT;
        end else begin
          cnt_d = cnt_q - GW'(1);
        end
      end
      S_WAIT: begin
        abort_pend_d = abort_now;
        if (tx_end) begin
          if (idx_inc < {1'b0, len_q}) begin
            idx_d   = idx_inc[LW-1:0];
            cnt_d   = CNT_BYTE;
            state_d = S_GAP;
          end else if (loop && !abort_now && (len_clamped != '0)) begin
            // A loop restart takes a fresh snapshot. A zero length at that
            // point ends the run normally instead of spinning with nothing to send.
            msg_d   = msg;
            len_d   = len_clamped;
            idx_d   = '0;
            cnt_d   = CNT_MSG;
            state_d = S_GAP;
          end else begin
            state_d      = S_IDLE;
            done_d       = !abort_now;
            abort_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      msg_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  reflet_uart_uart #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart (
    .clk              (clk),
    .reset            (reset),
    .data_i           (tx_byte),
    .start_transmit_i (tx_start),
    .tx_o             (tx),
    .end_transmit_o   (tx_end),
    .rx_i             (rx),
    .data_o           (rx_data),
    .receive_done_o   (rx_valid)
  );

endmodule

// reflet_uart_uart
//   8N1 UART with a fixed divider.
//
// Ports
//   clk, reset (active-low, async)
//   data_i / start_transmit_i   byte to send and its 1-cycle request; a
//                               request is ignored while a frame is in flight
//   tx_o                        transmit line, idle high
//   end_transmit_o              1-cycle pulse once the stop bit has fully elapsed
//   rx_i                        receive line (asynchronous)
//   data_o / receive_done_o     last received byte and its 1-cycle valid pulse
module reflet_uart_uart #(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       start_transmit_i,
  output logic       tx_o,
  output logic       end_transmit_o,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       receive_done_o
);

  localparam int unsigned CPB_RAW = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CPB     = (CPB_RAW > 2) ? CPB_RAW : 2;
  localparam int unsigned HALF    = CPB / 2;
  localparam int unsigned CW      = $clog2(CPB);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  // Transmit: a 10-bit frame is shifted out LSB first. Once the frame has
  // been sent, the register holds the stop bit, so the line rests high.
  logic          tx_active_q;
  logic [9:0]    tx_shift_q;
  logic [3:0]    tx_bit_q;
  logic [CW-1:0] tx_cnt_q;
  logic          tx_end_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_active_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      tx_end_q    <= 1'b0;
    end else begin
      tx_end_q <= 1'b0;
      if (!tx_active_q) begin
        if (start_transmit_i) begin
          tx_active_q <= 1'b1;
          tx_shift_q  <= {1'b1, data_i, 1'b0};
          tx_bit_q    <= '0;
          tx_cnt_q    <= '0;
        end
      end else if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_active_q <= 1'b0;
          tx_end_q    <= 1'b1;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + CW'(1);
      end
    end
  end

  assign tx_o           = tx_shift_q[0];
  assign end_transmit_o = tx_end_q;

  // Receive: the line is synchronised, then the start bit is confirmed at
  // mid-bit. After that, each bit is sampled one bit period later.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t     rx_state_q;
  logic [1:0]    rx_sync_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_done_q;
  logic          rx_s;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_sync_q  <= '1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_i};
      rx_done_q <= 1'b0;
      unique case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s) begin
              rx_data_q <= rx_shift_q;
              rx_done_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign data_o         = rx_data_q;
  assign receive_done_o = rx_done_q;

endmodule
